addsub_entry_ctrl: RTL and testbench

ADDSUB_ENTRY_CTRL -- requirements
Module: addsub_entry_ctrl

---
 rtl/addsub_entry_ctrl.sv | 160 ++++++++++++++++
 tb/tb_addsub_entry_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_entry_ctrl.sv
// Operand/opcode entry controller for a 4-bit add/sub stage.
// Two debounced push-buttons step a five-state FSM that captures A, B and
// the operation from the switches, samples the downstream sum for one cycle,
// and reports result, overflow and a one-cycle done pulse.
module addsub_entry_ctrl #(
    parameter int DB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn_enter,
    input  logic       btn_clr,
    input  logic [3:0] sum_in,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    output logic       sub_out,
    output logic [3:0] result,
    output logic       ovf,
    output logic       done,
    output logic [2:0] state_led
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        CALC   = 3'd3,
        SHOW   = 3'd4
    } state_t;

    // Index 0 = enter button, index 1 = clear button.
    logic [1:0]    r_s1;
    logic [1:0]    r_s2;
    logic [1:0]    r_lvl;
    logic [1:0]    r_lvl_q;
    logic [CW-1:0] r_cnt [2];

    logic          w_ent_evt;
    logic          w_clr_evt;
    logic          w_ovf;

    state_t        r_state;
    logic [3:0]    r_a;
    logic [3:0]    r_b;
    logic          r_sub;
    logic [3:0]    r_result;
    logic          r_ovf;
    logic          r_done;

    // Synchronize both buttons and accept a new level after DB_CYCLES
    // consecutive samples that differ from the currently accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_lvl   <= '0;
            r_lvl_q <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1    <= {btn_clr, btn_enter};
            r_s2    <= r_s1;
            r_lvl_q <= r_lvl;
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_s2[i] != r_lvl[i]) begin
                    if (r_cnt[i] == DB_MAX) begin
                        r_lvl[i] <= r_s2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_ent_evt = r_lvl[0] & ~r_lvl_q[0];
    assign w_clr_evt = r_lvl[1] & ~r_lvl_q[1];

    // Signed overflow of the returned sum, judged against the latched operands.
    always_comb begin
        w_ovf = 1'b0;
        if (r_sub) begin
            w_ovf = (r_a[3] != r_b[3]) && (sum_in[3] != r_a[3]);
        end else begin
            w_ovf = (r_a[3] == r_b[3]) && (sum_in[3] != r_a[3]);
        end
    end

    // Entry sequencer; clear outranks enter in every state, CALC is one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= GET_A;
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_clr_evt) begin
                r_state  <= GET_A;
                r_a      <= '0;
                r_b      <= '0;
                r_sub    <= 1'b0;
                r_result <= '0;
                r_ovf    <= 1'b0;
            end else begin
                case (r_state)
                    GET_A: begin
                        if (w_ent_evt) begin
                            r_a     <= sw;
                            r_state <= GET_B;
                        end
                    end
                    GET_B: begin
                        if (w_ent_evt) begin
                            r_b     <= sw;
                            r_state <= GET_OP;
                        end
                    end
                    GET_OP: begin
                        if (w_ent_evt) begin
                            r_sub   <= sw[0];
                            r_state <= CALC;
                        end
                    end
                    CALC: begin
                        r_result <= sum_in;
                        r_ovf    <= w_ovf;
                        r_done   <= 1'b1;
                        r_state  <= SHOW;
                    end
                    SHOW: begin
                        if (w_ent_evt) begin
                            r_state <= GET_A;
                        end
                    end
                    default: r_state <= GET_A;
                endcase
            end
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign sub_out   = r_sub;
    assign result    = r_result;
    assign ovf       = r_ovf;
    assign done      = r_done;
    assign state_led = r_state;

endmodule

// File: tb/tb_addsub_entry_ctrl.sv
// Directed bench for addsub_entry_ctrl: table of complete A/B/op entries
// plus hand-written debounce, clear-priority and reset-in-CALC sequences.
module tb_addsub_entry_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = '0;
    logic       btn_enter = 1'b0;
    logic       btn_clr = 1'b0;
    logic [3:0] sum_in = '0;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic       sub_out;
    logic [3:0] result;
    logic       ovf;
    logic       done;
    logic [2:0] state_led;

    addsub_entry_ctrl #(.DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .btn_enter (btn_enter),
        .btn_clr   (btn_clr),
        .sum_in    (sum_in),
        .a_out     (a_out),
        .b_out     (b_out),
        .sub_out   (sub_out),
        .result    (result),
        .ovf       (ovf),
        .done      (done),
        .state_led (state_led)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    // Observer: state transitions and done-high cycles seen at negedge.
    logic [2:0] trans[$];
    logic [2:0] prev_state = 3'd0;
    int         done_cnt = 0;
    int         done_bad = 0;

    always @(negedge clk) begin
        if (state_led != prev_state) trans.push_back(state_led);
        prev_state = state_led;
        if (done === 1'b1) begin
            done_cnt++;
            if (state_led != 3'd4) done_bad++;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic en, input logic clr, input int n);
        @(negedge clk);
        btn_enter = en;
        btn_clr   = clr;
        repeat (n) @(negedge clk);
        btn_enter = 1'b0;
        btn_clr   = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic clear_obs();
        trans.delete();
        done_cnt = 0;
        done_bad = 0;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic [3:0] sum;
        logic       exp_sub;
        logic [3:0] exp_res;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[6];
    logic [2:0] exp_seq[4];

    initial begin
        vecs[0] = '{a:4'h5, b:4'h3, op:4'h0, sum:4'h8, exp_sub:1'b0, exp_res:4'h8, exp_ovf:1'b1};
        vecs[1] = '{a:4'h3, b:4'h5, op:4'h1, sum:4'hE, exp_sub:1'b1, exp_res:4'hE, exp_ovf:1'b0};
        vecs[2] = '{a:4'h8, b:4'h1, op:4'h1, sum:4'h7, exp_sub:1'b1, exp_res:4'h7, exp_ovf:1'b1};
        vecs[3] = '{a:4'h2, b:4'h3, op:4'hE, sum:4'h5, exp_sub:1'b0, exp_res:4'h5, exp_ovf:1'b0};
        vecs[4] = '{a:4'h9, b:4'hE, op:4'h3, sum:4'hB, exp_sub:1'b1, exp_res:4'hB, exp_ovf:1'b0};
        vecs[5] = '{a:4'h9, b:4'hE, op:4'h0, sum:4'h7, exp_sub:1'b0, exp_res:4'h7, exp_ovf:1'b1};
        exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state", {5'd0, state_led}, 8'd0);
        chk("rst_a", {4'd0, a_out}, 8'd0);
        chk("rst_b", {4'd0, b_out}, 8'd0);
        chk("rst_res", {4'd0, result}, 8'd0);
        chk("rst_flags", {5'd0, sub_out, ovf, done}, 8'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Full entry sequences
        for (int i = 0; i < 6; i++) begin
            clear_obs();
            sw = vecs[i].a;
            press(1'b1, 1'b0, DB + 2);
            chk("a_cap", {4'd0, a_out}, {4'd0, vecs[i].a});
            chk("st_getb", {5'd0, state_led}, 8'd1);
            sw = vecs[i].b;
            press(1'b1, 1'b0, DB + 2);
            chk("b_cap", {4'd0, b_out}, {4'd0, vecs[i].b});
            sw = vecs[i].op;
            sum_in = vecs[i].sum;
            press(1'b1, 1'b0, DB + 2);
            chk("sub_out", {7'd0, sub_out}, {7'd0, vecs[i].exp_sub});
            chk("result", {4'd0, result}, {4'd0, vecs[i].exp_res});
            chk("ovf", {7'd0, ovf}, {7'd0, vecs[i].exp_ovf});
            chk("done_cycles", 8'(done_cnt), 8'd1);
            chk("done_in_show", 8'(done_bad), 8'd0);
            chk("n_trans", 8'(trans.size()), 8'd4);
            for (int k = 0; k < 4; k++) begin
                if (k < trans.size()) chk("trans_seq", {5'd0, trans[k]}, {5'd0, exp_seq[k]});
            end
            press(1'b1, 1'b0, DB + 2);
            chk("show_to_a", {5'd0, state_led}, 8'd0);
            chk("res_hold", {4'd0, result}, {4'd0, vecs[i].exp_res});
        end

        // Short pulse and bounce must not be accepted
        clear_obs();
        sw = 4'hA;
        press(1'b1, 1'b0, DB - 1);
        begin
            logic [6:0] bounce;
            bounce = 7'b1101011;
            for (int k = 0; k < 7; k++) begin
                @(negedge clk);
                btn_enter = bounce[k];
            end
            @(negedge clk);
            btn_enter = 1'b0;
            repeat (12) @(negedge clk);
        end
        chk("glitch_state", {5'd0, state_led}, 8'd0);
        chk("glitch_trans", 8'(trans.size()), 8'd0);
        press(1'b1, 1'b0, DB + 2);
        chk("clean_trans", 8'(trans.size()), 8'd1);
        chk("clean_state", {5'd0, state_led}, 8'd1);
        chk("clean_a", {4'd0, a_out}, 8'h0A);

        // Clear and enter accepted together in GET_B
        clear_obs();
        sw = 4'h6;
        press(1'b1, 1'b1, DB + 2);
        chk("clr_state", {5'd0, state_led}, 8'd0);
        chk("clr_a", {4'd0, a_out}, 8'd0);
        chk("clr_b", {4'd0, b_out}, 8'd0);
        chk("clr_res", {4'd0, result}, 8'd0);
        chk("clr_flags", {5'd0, sub_out, ovf, done}, 8'd0);
        chk("clr_done", 8'(done_cnt), 8'd0);

        // Reset asserted while in CALC
        sw = 4'h7;
        press(1'b1, 1'b0, DB + 2);
        sw = 4'h7;
        press(1'b1, 1'b0, DB + 2);
        sw = 4'h1;
        sum_in = 4'h0;
        clear_obs();
        @(negedge clk);
        btn_enter = 1'b1;
        begin
            int w;
            w = 0;
            while (state_led != 3'd3 && w < 40) begin
                @(negedge clk);
                w++;
            end
            chk("reach_calc", {5'd0, state_led}, 8'd3);
        end
        rst_n = 1'b0;
        #1;
        chk("rcalc_state", {5'd0, state_led}, 8'd0);
        chk("rcalc_ab", {a_out, b_out}, 8'd0);
        chk("rcalc_res", {4'd0, result}, 8'd0);
        chk("rcalc_flags", {5'd0, sub_out, ovf, done}, 8'd0);
        repeat (3) @(negedge clk);
        chk("rcalc_nodone", 8'(done_cnt), 8'd0);

        // Button held across reset release needs a full debounce window
        rst_n = 1'b1;
        repeat (DB) @(negedge clk);
        chk("held_early", {5'd0, state_led}, 8'd0);
        begin
            int w;
            w = 0;
            while (state_led != 3'd1 && w < 30) begin
                @(negedge clk);
                w++;
            end
            chk("held_event", {5'd0, state_led}, 8'd1);
        end
        btn_enter = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule
